// File: rtl/apb_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_sequencer
// Purpose  : Upstream command sequencer for the APB GPIO/UART subsystem.
//            Commands are queued in a small FIFO. They are issued to the
//            subsystem one at a time. The module waits for completion or
//            timeout, then returns read data and error status through a
//            valid/ready response port.
// Ports    : PCLK/PRESET            clock, synchronous active-high reset
//            cmd_*                  command push port (valid/ready)
//            rsp_*                  response port (valid/ready)
//            READ1_WRITE0, TRANSFER_FLAG, APB_*, IN_STRB, Slave_Select
//                                   transfer request to the subsystem
//            APB_readData, xfer_done, xfer_err
//                                   completion from the subsystem
//            busy, timeout_flag     status (timeout_flag is sticky)
// Revision : 1.0 - initial release
// ============================================================================
module apb_cmd_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int STRB_WIDTH     = 4,
    parameter int SLAVES_NUM     = 2,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_rw,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    input  logic [STRB_WIDTH-1:0]    cmd_strb,
    input  logic [SLAVES_NUM-1:0]    cmd_sel,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_rw,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err,
    output logic                     READ1_WRITE0,
    output logic                     TRANSFER_FLAG,
    output logic [ADDRESS_WIDTH-1:0] APB_writeAddress,
    output logic [ADDRESS_WIDTH-1:0] APB_readAddress,
    output logic [DATA_WIDTH-1:0]    APB_writeData,
    output logic [STRB_WIDTH-1:0]    IN_STRB,
    output logic [SLAVES_NUM-1:0]    Slave_Select,
    input  logic [DATA_WIDTH-1:0]    APB_readData,
    input  logic                     xfer_done,
    input  logic                     xfer_err,
    output logic                     busy,
    output logic                     timeout_flag
);

    localparam int c_PTR_W = $clog2(CMD_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0]    c_FULL     = c_CNT_W'(CMD_DEPTH);
    localparam logic [c_TMR_W-1:0]    c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SLAVES_NUM-1:0] c_SEL_GPIO = SLAVES_NUM'(1);
    localparam logic [SLAVES_NUM-1:0] c_SEL_UART = SLAVES_NUM'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Command FIFO storage
    logic                     r_fifo_rw    [CMD_DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_fifo_addr  [CMD_DEPTH];
    logic [DATA_WIDTH-1:0]    r_fifo_wdata [CMD_DEPTH];
    logic [STRB_WIDTH-1:0]    r_fifo_strb  [CMD_DEPTH];
    logic [SLAVES_NUM-1:0]    r_fifo_sel   [CMD_DEPTH];
    logic [c_PTR_W-1:0]       r_wr_ptr;
    logic [c_PTR_W-1:0]       r_rd_ptr;
    logic [c_CNT_W-1:0]       r_count;

    // Command currently on the bus
    logic                     r_rw;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [STRB_WIDTH-1:0]    r_strb;
    logic [SLAVES_NUM-1:0]    r_sel;

    logic [c_TMR_W-1:0]       r_timer;
    logic                     r_rsp_rw;
    logic [DATA_WIDTH-1:0]    r_rsp_rdata;
    logic                     r_rsp_err;
    logic                     r_timeout_flag;

    logic w_push;
    logic w_pop;
    logic w_head_sel_ok;
    logic w_in_wait;
    logic w_timeout;

    // Space is judged on the registered count only, so a pop in the same
    // cycle never makes room for a push early.
    assign cmd_ready     = (r_count != c_FULL);
    assign w_push        = cmd_valid && cmd_ready;
    assign w_head_sel_ok = (r_fifo_sel[r_rd_ptr] == c_SEL_GPIO) ||
                           (r_fifo_sel[r_rd_ptr] == c_SEL_UART);
    assign w_in_wait     = (r_state == S_WAIT);
    assign w_timeout     = (r_timer == c_TMR_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and pop decision
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop = 1'b1;
                    // A bad slave select never touches the bus.
                    w_next_state = w_head_sel_ok ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (xfer_done || w_timeout) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed; validity is tracked by r_count)
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (w_push) begin
            r_fifo_rw[r_wr_ptr]    <= cmd_rw;
            r_fifo_addr[r_wr_ptr]  <= cmd_addr;
            r_fifo_wdata[r_wr_ptr] <= cmd_wdata;
            r_fifo_strb[r_wr_ptr]  <= cmd_strb;
            r_fifo_sel[r_wr_ptr]   <= cmd_sel;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, holding registers, timer and response
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_rw           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_strb         <= '0;
            r_sel          <= '0;
            r_timer        <= '0;
            r_rsp_rw       <= 1'b0;
            r_rsp_rdata    <= '0;
            r_rsp_err      <= 1'b0;
            r_timeout_flag <= 1'b0;
        end else begin
            // Pointers wrap naturally because CMD_DEPTH is a power of two.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_pop) begin
                r_rw     <= r_fifo_rw[r_rd_ptr];
                r_addr   <= r_fifo_addr[r_rd_ptr];
                r_wdata  <= r_fifo_wdata[r_rd_ptr];
                r_strb   <= r_fifo_strb[r_rd_ptr];
                r_sel    <= r_fifo_sel[r_rd_ptr];
                r_rsp_rw <= r_fifo_rw[r_rd_ptr];
                if (!w_head_sel_ok) begin
                    r_rsp_err   <= 1'b1;
                    r_rsp_rdata <= '0;
                end
            end

            if (w_in_wait) begin
                r_timer <= r_timer + 1'b1;
                // Completion takes priority over a coincident timeout.
                if (xfer_done) begin
                    r_rsp_err   <= xfer_err;
                    r_rsp_rdata <= (r_rw && !xfer_err) ? APB_readData : '0;
                end else if (w_timeout) begin
                    r_rsp_err      <= 1'b1;
                    r_rsp_rdata    <= '0;
                    r_timeout_flag <= 1'b1;
                end
            end

            if ((r_state == S_RESP) && rsp_ready) begin
                r_timer <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: bus fields are only driven while a transfer is in WAIT.
    // ------------------------------------------------------------------
    assign TRANSFER_FLAG    = w_in_wait;
    assign READ1_WRITE0     = w_in_wait && r_rw;
    assign APB_writeAddress = w_in_wait ? r_addr : '0;
    assign APB_readAddress  = w_in_wait ? r_addr : '0;
    assign APB_writeData    = (w_in_wait && !r_rw) ? r_wdata : '0;
    assign IN_STRB          = (w_in_wait && !r_rw) ? r_strb : '0;
    assign Slave_Select     = w_in_wait ? r_sel : '0;

    assign rsp_valid    = (r_state == S_RESP);
    assign rsp_rw       = r_rsp_rw;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;
    assign busy         = (r_state != S_IDLE) || (r_count != '0);
    assign timeout_flag = r_timeout_flag;

endmodule
`default_nettype wire
